// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer controller: raster-order writer vs. random-address
// reader, round-robin on contention, one-cycle read latency.
module frame_buffer_arbiter #(
   parameter int P_COLUMNS     = 640,
   parameter int P_ROWS        = 4,
   parameter int P_PIXEL_DEPTH = 24,
   localparam int CW = $clog2(P_COLUMNS),
   localparam int RW = $clog2(P_ROWS),
   localparam int FW = $clog2(P_ROWS + 1)
) (
   input  logic                     I_CLK,
   input  logic                     I_RESET,
   input  logic                     I_ENABLE,
   input  logic                     I_WR_VALID,
   input  logic [P_PIXEL_DEPTH-1:0] I_WR_PIXEL,
   output logic                     O_WR_READY,
   input  logic                     I_RD_VALID,
   input  logic [RW-1:0]            I_RD_ROW,
   input  logic [CW-1:0]            I_RD_COL,
   output logic                     O_RD_READY,
   output logic                     O_RD_DATA_VALID,
   output logic [P_PIXEL_DEPTH-1:0] O_RD_DATA,
   output logic                     O_RD_ERR,
   output logic [RW-1:0]            O_WR_ROW,
   output logic [CW-1:0]            O_WR_COL,
   output logic [FW-1:0]            O_ROWS_FILLED,
   output logic                     O_LINE_DONE,
   output logic                     O_FB_ENABLE,
   output logic [RW-1:0]            O_FB_ROW,
   output logic [CW-1:0]            O_FB_COL,
   output logic [P_PIXEL_DEPTH-1:0] O_FB_PIXEL,
   output logic                     O_FB_WRITE_ENABLE,
   output logic                     O_FB_READ_ENABLE,
   input  logic [P_PIXEL_DEPTH-1:0] I_FB_PIXEL
);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [FW-1:0] r_filled;
   logic          r_line_done;
   logic          r_last_rd;
   logic          r_rd_pend;
   logic          r_rd_err;

   logic w_act, w_wr_gnt, w_rd_gnt, w_rd_inrange, w_last_col, w_rd_out;

   assign w_act        = I_ENABLE & ~I_RESET;
   // r_last_rd high means the reader had the last grant, so the writer wins a tie
   assign w_wr_gnt     = w_act & I_WR_VALID & (~I_RD_VALID | r_last_rd);
   assign w_rd_gnt     = w_act & I_RD_VALID & (~I_WR_VALID | ~r_last_rd);
   assign w_rd_inrange = (32'(I_RD_COL) < 32'(P_COLUMNS)) && (32'(I_RD_ROW) < 32'(P_ROWS));
   assign w_last_col   = (r_col == CW'(P_COLUMNS - 1));

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         r_col       <= '0;
         r_row       <= '0;
         r_filled    <= '0;
         r_line_done <= 1'b0;
         r_last_rd   <= 1'b1;
         r_rd_pend   <= 1'b0;
         r_rd_err    <= 1'b0;
      end else begin
         r_line_done <= w_wr_gnt & w_last_col;
         // A pending result is held across disabled cycles, as the buffer holds q
         if (I_ENABLE) begin
            r_rd_pend <= w_rd_gnt;
            r_rd_err  <= w_rd_gnt & ~w_rd_inrange;
         end
         if (w_wr_gnt)
            r_last_rd <= 1'b0;
         else if (w_rd_gnt)
            r_last_rd <= 1'b1;
         if (w_wr_gnt) begin
            if (w_last_col) begin
               r_col <= '0;
               r_row <= (r_row == RW'(P_ROWS - 1)) ? '0 : r_row + 1'b1;
               if (r_filled != FW'(P_ROWS))
                  r_filled <= r_filled + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   assign w_rd_out        = r_rd_pend & I_ENABLE & ~I_RESET;
   assign O_RD_DATA_VALID = w_rd_out;
   assign O_RD_ERR        = w_rd_out & r_rd_err;
   assign O_RD_DATA       = (w_rd_out & ~r_rd_err) ? I_FB_PIXEL : '0;

   assign O_WR_READY      = w_wr_gnt;
   assign O_RD_READY      = w_rd_gnt;
   assign O_WR_ROW        = r_row;
   assign O_WR_COL        = r_col;
   assign O_ROWS_FILLED   = r_filled;
   assign O_LINE_DONE     = r_line_done;
   assign O_FB_ENABLE     = I_ENABLE | I_RESET;

   always_comb begin
      O_FB_ROW          = r_row;
      O_FB_COL          = r_col;
      O_FB_PIXEL        = '0;
      O_FB_WRITE_ENABLE = 1'b0;
      O_FB_READ_ENABLE  = 1'b0;
      if (w_wr_gnt) begin
         O_FB_PIXEL        = I_WR_PIXEL;
         O_FB_WRITE_ENABLE = 1'b1;
      end else if (w_rd_gnt && w_rd_inrange) begin
         O_FB_ROW         = I_RD_ROW;
         O_FB_COL         = I_RD_COL;
         O_FB_READ_ENABLE = 1'b1;
      end
   end

endmodule
